// File: rtl/skolem_ashr_sweep_checker.sv
// skolem_ashr_sweep_checker
// Exhaustive sweep checker for a combinational W-bit bvashr Skolem block.
// Every (s, t) pair is driven out, the returned witness x is captured, and
// a fixed-length brute-force search decides whether s >>a x == t has any
// solution. Each vector is then classified as pass, fail or unsat, and the
// first failing vector is recorded.
// Optional build macro: SKOLEM_CHECK_STOP_ON_FAIL_EN
//   defined   -> the first failing vector ends the sweep immediately
//   undefined -> the sweep always covers all 2^(2W) vectors
module skolem_ashr_sweep_checker #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   s_out,
    output logic [W-1:0]   t_out,
    input  logic [W-1:0]   x_in,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   pass_cnt,
    output logic [2*W:0]   fail_cnt,
    output logic [2*W:0]   unsat_cnt,
    output logic           ff_valid,
    output logic [W-1:0]   ff_s,
    output logic [W-1:0]   ff_t,
    output logic [W-1:0]   ff_x
);

    localparam int VW = 2 * W;
    localparam int CW = 2 * W + 1;
    localparam logic [3:0] SETTLE_M1 = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_SAMPLE,
        ST_SEARCH,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   v_q, v_d;
    logic [3:0]      wait_q, wait_d;
    logic [W-1:0]    x_cap_q, x_cap_d;
    logic [W-1:0]    c_q, c_d;
    logic            exists_q, exists_d;
    logic [CW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   fail_q, fail_d;
    logic [CW-1:0]   unsat_q, unsat_d;
    logic            ff_valid_q, ff_valid_d;
    logic [W-1:0]    ff_s_q, ff_s_d;
    logic [W-1:0]    ff_t_q, ff_t_d;
    logic [W-1:0]    ff_x_q, ff_x_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W-1:0]    s_cur;
    logic [W-1:0]    t_cur;
    logic            search_hit;
    logic            witness_ok;
    logic            stop_now;

    // Arithmetic right shift by an unsigned amount; shifts of W or more
    // saturate to W copies of the sign bit.
    function automatic logic [W-1:0] ashr(input logic [W-1:0] a, input logic [W-1:0] amt);
        if (32'(amt) >= W) begin
            ashr = {W{a[W-1]}};
        end else begin
            ashr = $signed(a) >>> amt;
        end
    endfunction

    assign s_cur      = v_q[VW-1:W];
    assign t_cur      = v_q[W-1:0];
    assign search_hit = (ashr(s_cur, c_q) == t_cur);
    assign witness_ok = (ashr(s_cur, x_cap_q) == t_cur);

    assign s_out     = s_cur;
    assign t_out     = t_cur;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign unsat_cnt = unsat_q;
    assign ff_valid  = ff_valid_q;
    assign ff_s      = ff_s_q;
    assign ff_t      = ff_t_q;
    assign ff_x      = ff_x_q;

    // Next-state logic: sequences drive/settle/sample/search/check per vector.
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        wait_d     = wait_q;
        x_cap_d    = x_cap_q;
        c_d        = c_q;
        exists_d   = exists_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        unsat_d    = unsat_q;
        ff_valid_d = ff_valid_q;
        ff_s_d     = ff_s_q;
        ff_t_d     = ff_t_q;
        ff_x_d     = ff_x_q;
        busy_d     = busy_q;
        done_d     = done_q;
        stop_now   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pass_d     = '0;
                    fail_d     = '0;
                    unsat_d    = '0;
                    ff_valid_d = 1'b0;
                    ff_s_d     = '0;
                    ff_t_d     = '0;
                    ff_x_d     = '0;
                    v_d        = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (SETTLE == 0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d  = SETTLE_M1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                x_cap_d  = x_in;
                exists_d = 1'b0;
                c_d      = '0;
                state_d  = ST_SEARCH;
            end
            ST_SEARCH: begin
                exists_d = exists_q | search_hit;
                if (c_q == {W{1'b1}}) begin
                    state_d = ST_CHECK;
                end else begin
                    c_d = c_q + W'(1);
                end
            end
            ST_CHECK: begin
                if (!exists_q) begin
                    unsat_d = unsat_q + CW'(1);
                end else if (witness_ok) begin
                    pass_d = pass_q + CW'(1);
                end else begin
                    fail_d = fail_q + CW'(1);
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_s_d     = s_cur;
                        ff_t_d     = t_cur;
                        ff_x_d     = x_cap_q;
                    end
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
                    stop_now = 1'b1;
`endif
                end
                if (stop_now || (v_q == {VW{1'b1}})) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            v_q        <= '0;
            wait_q     <= '0;
            x_cap_q    <= '0;
            c_q        <= '0;
            exists_q   <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            unsat_q    <= '0;
            ff_valid_q <= 1'b0;
            ff_s_q     <= '0;
            ff_t_q     <= '0;
            ff_x_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            wait_q     <= wait_d;
            x_cap_q    <= x_cap_d;
            c_q        <= c_d;
            exists_q   <= exists_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            unsat_q    <= unsat_d;
            ff_valid_q <= ff_valid_d;
            ff_s_q     <= ff_s_d;
            ff_t_q     <= ff_t_d;
            ff_x_q     <= ff_x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_skolem_ashr_sweep_checker.sv
// Testbench for skolem_ashr_sweep_checker: directed sweeps against a
// behavioural Skolem block (correct, forced-zero, or 3-cycle delayed).
module tb_skolem_ashr_sweep_checker;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         start3;
    logic         fault_mode;

    logic [W-1:0] s_out, t_out, x_in;
    logic         busy, done;
    logic [2*W:0] pass_cnt, fail_cnt, unsat_cnt;
    logic         ff_valid;
    logic [W-1:0] ff_s, ff_t, ff_x;

    logic [W-1:0] s3, t3, x3;
    logic         busy3, done3;
    logic [2*W:0] pass3, fail3, unsat3;
    logic         ffv3;
    logic [W-1:0] ffs3, fft3, ffx3;
    logic [W-1:0] d1, d2, d3;

    int vectors = 0;
    int miscompares = 0;

    skolem_ashr_sweep_checker #(.W(W), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_out(s_out), .t_out(t_out), .x_in(x_in),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .unsat_cnt(unsat_cnt),
        .ff_valid(ff_valid), .ff_s(ff_s), .ff_t(ff_t), .ff_x(ff_x)
    );

    skolem_ashr_sweep_checker #(.W(W), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .s_out(s3), .t_out(t3), .x_in(x3),
        .busy(busy3), .done(done3),
        .pass_cnt(pass3), .fail_cnt(fail3), .unsat_cnt(unsat3),
        .ff_valid(ffv3), .ff_s(ffs3), .ff_t(fft3), .ff_x(ffx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural arithmetic shift used only by the stand-in Skolem block.
    function automatic logic [W-1:0] model_ashr(input logic [W-1:0] a, input logic [W-1:0] amt);
        logic [W-1:0] r;
        r = a;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(amt)) r = {r[W-1], r[W-1:1]};
        end
        return r;
    endfunction

    // Stand-in Skolem block: smallest x that satisfies s >>a x == t, else 0.
    function automatic logic [W-1:0] skolem(input logic [W-1:0] s, input logic [W-1:0] t);
        for (int c = 0; c < 16; c++) begin
            if (model_ashr(s, 4'(c)) == t) return 4'(c);
        end
        return 4'd0;
    endfunction

    assign x_in = fault_mode ? 4'd0 : skolem(s_out, t_out);

    // Three-stage delay line modelling a slow Skolem block for the SETTLE=3 instance.
    always @(posedge clk) begin
        d1 <= skolem(s3, t3);
        d2 <= d1;
        d3 <= d2;
    end
    assign x3 = d3;

    // Pulse start on the chosen instance and count cycles until done rises;
    // optionally re-pulse start at a given cycle while the sweep is busy.
    task automatic run_sweep(input bit use3, input int pulse_at, output int cycles);
        int n;
        if (use3) start3 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start3 = 1'b0;
        n = 0;
        while (!(use3 ? done3 : done) && n < 20000) begin
            if (n == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        cycles = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start3 = 1'b0;
        fault_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({busy, done, ff_valid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, ff_valid});
        end
        vectors++;
        if ({s_out, t_out, ff_s, ff_t, ff_x} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_operands: got %h expected 0", {s_out, t_out, ff_s, ff_t, ff_x});
        end
        vectors++;
        if ({pass_cnt, fail_cnt, unsat_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", pass_cnt, fail_cnt, unsat_cnt);
        end
    endtask

    task automatic test_correct_sweep();
        int cyc;
        fault_mode = 1'b0;
        run_sweep(1'b0, -1, cyc);
        vectors++;
        if (cyc !== 5120) begin
            miscompares++;
            $display("[TB] FAIL correct_cycles: got %0d expected 5120", cyc);
        end
        vectors++;
        if (pass_cnt !== 9'd50 || fail_cnt !== 9'd0 || unsat_cnt !== 9'd206) begin
            miscompares++;
            $display("[TB] FAIL correct_counts: got %0d/%0d/%0d expected 50/0/206", pass_cnt, fail_cnt, unsat_cnt);
        end
        vectors++;
        if (ff_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL correct_flags: got ffv=%b busy=%b expected 0/0", ff_valid, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || pass_cnt !== 9'd50 || unsat_cnt !== 9'd206) begin
            miscompares++;
            $display("[TB] FAIL done_hold: got done=%b pass=%0d unsat=%0d expected 1/50/206", done, pass_cnt, unsat_cnt);
        end
    endtask

    task automatic test_faulty_sweep();
        int cyc;
        fault_mode = 1'b1;
        run_sweep(1'b0, -1, cyc);
`ifdef SKOLEM_CHECK_STOP_ON_FAIL_EN
        vectors++;
        if (cyc !== 340) begin
            miscompares++;
            $display("[TB] FAIL faulty_stop_cycles: got %0d expected 340", cyc);
        end
        vectors++;
        if (pass_cnt !== 9'd1 || fail_cnt !== 9'd1 || unsat_cnt !== 9'd15) begin
            miscompares++;
            $display("[TB] FAIL faulty_stop_counts: got %0d/%0d/%0d expected 1/1/15", pass_cnt, fail_cnt, unsat_cnt);
        end
`else
        vectors++;
        if (cyc !== 5120) begin
            miscompares++;
            $display("[TB] FAIL faulty_cycles: got %0d expected 5120", cyc);
        end
        vectors++;
        if (pass_cnt !== 9'd16 || fail_cnt !== 9'd34 || unsat_cnt !== 9'd206) begin
            miscompares++;
            $display("[TB] FAIL faulty_counts: got %0d/%0d/%0d expected 16/34/206", pass_cnt, fail_cnt, unsat_cnt);
        end
`endif
        vectors++;
        if ({ff_valid, ff_s, ff_t, ff_x} !== {1'b1, 4'b0001, 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL first_fail: got v=%b s=%h t=%h x=%h expected v=1 s=1 t=0 x=0", ff_valid, ff_s, ff_t, ff_x);
        end
        fault_mode = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || s_out !== 4'd3) begin
            miscompares++;
            $display("[TB] FAIL mid_sweep_progress: got busy=%b s=%0d expected 1/3", busy, s_out);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({busy, done, ff_valid, s_out, t_out, pass_cnt, fail_cnt, unsat_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_clear: got busy=%b done=%b s=%0d t=%0d pass=%0d unsat=%0d expected all 0",
                     busy, done, s_out, t_out, pass_cnt, unsat_cnt);
        end
        run_sweep(1'b0, -1, cyc);
        vectors++;
        if (cyc !== 5120 || pass_cnt !== 9'd50 || fail_cnt !== 9'd0 || unsat_cnt !== 9'd206) begin
            miscompares++;
            $display("[TB] FAIL after_reset_sweep: got cyc=%0d %0d/%0d/%0d expected 5120 50/0/206",
                     cyc, pass_cnt, fail_cnt, unsat_cnt);
        end
    endtask

    task automatic test_settle3();
        int cyc;
        run_sweep(1'b1, -1, cyc);
        vectors++;
        if (cyc !== 5632) begin
            miscompares++;
            $display("[TB] FAIL settle3_cycles: got %0d expected 5632", cyc);
        end
        vectors++;
        if (pass3 !== 9'd50 || fail3 !== 9'd0 || unsat3 !== 9'd206 || ffv3 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL settle3_counts: got %0d/%0d/%0d ffv=%b expected 50/0/206 ffv=0", pass3, fail3, unsat3, ffv3);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        run_sweep(1'b0, 100, cyc);
        vectors++;
        if (cyc !== 5120) begin
            miscompares++;
            $display("[TB] FAIL busy_start_cycles: got %0d expected 5120", cyc);
        end
        vectors++;
        if (pass_cnt !== 9'd50 || fail_cnt !== 9'd0 || unsat_cnt !== 9'd206) begin
            miscompares++;
            $display("[TB] FAIL busy_start_counts: got %0d/%0d/%0d expected 50/0/206", pass_cnt, fail_cnt, unsat_cnt);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_correct_sweep();
        test_faulty_sweep();
        test_reset_mid_sweep();
        test_settle3();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/skolem_ashr_sweep_checker.md
Name: skolem_ashr_sweep_checker

Overview:
- Exhaustive verification stage placed directly downstream of the combinational 4-bit bvashr Skolem-function block.
- Drives every (s, t) operand pair into that block and captures the witness x it returns.
- Computes the ground-truth solvability of s >>a x == t by brute force over all x, then checks the witness.
- Accumulates pass / fail / unsat counts and records the first failing vector, for on-board or simulation sign-off.

Parameters:
- W, 4, operand width in bits; the sweep covers 2^(2W) vectors.
- SETTLE, 1, cycles to wait after driving s/t before sampling x_in (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a sweep when idle or done
- s_out  output  W  operand s to the Skolem block
- t_out  output  W  target t to the Skolem block
- x_in  input  W  witness x from the Skolem block
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep end until the next start
- pass_cnt  output  2W+1  solvable vectors with a correct witness
- fail_cnt  output  2W+1  solvable vectors with a wrong witness
- unsat_cnt  output  2W+1  unsolvable vectors (witness ignored)
- ff_valid  output  1  first-failure record is valid
- ff_s, ff_t, ff_x  output  W each  first failing s, t, x

Behaviour:
- Semantics: s >>a x is an arithmetic right shift of s by unsigned x. Any shift of W or more yields W copies of s[W-1].
- Reset: FSM goes to IDLE. s_out, t_out, counters, ff_* and ff_valid are all 0. busy=0, done=0.
- The vector index v is 2W bits, with s = v[2W-1:W] and t = v[W-1:0]. s_out and t_out are driven from v registers.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, SEARCH, CHECK, DONE.
- IDLE/DONE + start: clear counters and ff_*, set v=0 and busy=1, drop done, go to DRIVE.
- DRIVE, 1 cycle: s_out/t_out show v. Go to WAIT, or to SAMPLE if SETTLE=0.
- WAIT: lasts SETTLE cycles, then SAMPLE.
- SAMPLE, 1 cycle: register x_in into x_cap, clear the exists flag, set candidate c=0.
- SEARCH: exactly 2^W cycles with no early exit, so timing is fixed. Each cycle, exists |= ((s >>a c) == t) and c increments.
- CHECK, 1 cycle:
  - exists=0: unsat_cnt++.
  - exists=1 and (s >>a x_cap)==t: pass_cnt++.
  - Otherwise fail_cnt++. If ff_valid=0, capture ff_s/ff_t/ff_x and set ff_valid.
  - Then, if v is all ones, go to DONE. Otherwise v++ and go to DRIVE.
- Per-vector latency is 3+SETTLE+2^W cycles; with defaults a full sweep is 256×20 = 5120 cycles.
- DONE: busy=0, done=1. Counters and ff_* hold until the next start.
- start while busy is ignored.
- rst mid-sweep returns everything to its reset values on the next edge; the partial sweep is discarded.
- Invariant at DONE: pass_cnt + fail_cnt + unsat_cnt = 2^(2W).
- Counters cannot overflow, because their width is 2W+1.

Optional Feature:
- Macro: SKOLEM_CHECK_STOP_ON_FAIL_EN.
- When defined: the first fail in CHECK moves straight to DONE. Counters reflect only the vectors processed, and ff_* hold the failing vector.
- When undefined: the sweep always completes all 2^(2W) vectors.

Test Plan:
- Correct Skolem model, default parameters, start pulse → done after exactly 5120 cycles; pass_cnt=50, fail_cnt=0, unsat_cnt=206, ff_valid=0.
- Model forced to return x=4'b0000 → pass_cnt=16 (t==s cases), fail_cnt=34, unsat_cnt=206, ff_valid=1. First fail is ff_s=4'b0001, ff_t=4'b0000, ff_x=4'b0000.
- Same faulty model with SKOLEM_CHECK_STOP_ON_FAIL_EN defined → DONE right after vector v=0x10. pass_cnt=1, fail_cnt=1, unsat_cnt=15.
- Assert rst at cycle 1000 of a sweep, then start again → all outputs return to 0, and the second sweep gives the totals of scenario 1.
- SETTLE=3 with a 3-cycle-delayed model → sweep length 256×22 = 5632 cycles, pass_cnt=50, fail_cnt=0.
- Pulse start while busy → ignored; sweep length and counters are unchanged from scenario 1.
